// File: rtl/mux_nto1_reg.sv
// N-input, W-bit registered selector with valid/ready on both sides and a two-entry skid buffer.
// Optional select range check is enabled by defining MUX_SEL_RANGE_CHECK_EN.
module mux_nto1_reg #(
  parameter int W = 32,
  parameter int N = 4,
  localparam int S = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic [N*W-1:0] in_data,
  input  logic [S-1:0]   in_sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic [S-1:0]   out_sel,
  output logic           out_err,
  output logic           out_valid,
  input  logic           out_ready
);

  // Handshake: a beat moves on a side exactly in a cycle where valid & ready
  // are both high at the rising edge; valid never waits on ready.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_next;

  logic         in_acc, out_acc;
  logic         load_main, load_skid, main_from_skid;
  logic [W-1:0] pick_data, beat_data;
  logic [W-1:0] main_data, skid_data;
  logic [S-1:0] main_sel, skid_sel;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign in_acc    = in_valid & in_ready;
  assign out_acc   = out_valid & out_ready;

  // Out-of-range selects fall back to channel 0 unless the range check replaces them.
  always_comb begin
    pick_data = in_data[W-1:0];
    for (int k = 0; k < N; k++) begin
      if (in_sel == S'(k)) pick_data = in_data[k*W +: W];
    end
  end

`ifdef MUX_SEL_RANGE_CHECK_EN
  logic beat_err, main_err, skid_err;

  always_comb begin
    beat_err = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (in_sel == S'(k)) beat_err = 1'b0;
    end
  end

  assign beat_data = beat_err ? '0 : pick_data;
  assign out_err   = main_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_err <= 1'b0;
      skid_err <= 1'b0;
    end else begin
      if (load_main)           main_err <= beat_err;
      else if (main_from_skid) main_err <= skid_err;
      if (load_skid)           skid_err <= beat_err;
    end
  end
`else
  assign beat_data = pick_data;
  assign out_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // flush wins over every transition; a beat accepted alongside it is dropped.
  always_comb begin
    state_next     = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_acc) begin
            load_main  = 1'b1;
            state_next = ONE;
          end
        end
        ONE: begin
          if (in_acc && out_acc) begin
            load_main = 1'b1;
          end else if (in_acc) begin
            load_skid  = 1'b1;
            state_next = TWO;
          end else if (out_acc) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (out_acc) begin
            main_from_skid = 1'b1;
            state_next     = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      main_sel  <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else begin
      if (load_main) begin
        main_data <= beat_data;
        main_sel  <= in_sel;
      end else if (main_from_skid) begin
        main_data <= skid_data;
        main_sel  <= skid_sel;
      end
      if (load_skid) begin
        skid_data <= beat_data;
        skid_sel  <= in_sel;
      end
    end
  end

  assign out_data = main_data;
  assign out_sel  = main_sel;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed vector table plus hand sequences and a randomized stall scoreboard for mux_nto1_reg.
module tb_mux_nto1_reg;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic [127:0] in_data;
  logic [1:0]   in_sel = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_err;
  logic         out_valid;
  logic         out_ready = 1'b1;

  logic [95:0]  in_data3;
  logic [1:0]   in_sel3 = '0;
  logic         in_valid3 = 1'b0;
  logic         in_ready3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;
  logic         out_err3;
  logic         out_valid3;

  int tests = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mux_nto1_reg #(.W(32), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nto1_reg #(.W(32), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data3), .in_sel(in_sel3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_sel(out_sel3), .out_err(out_err3),
    .out_valid(out_valid3), .out_ready(1'b1)
  );

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic        ir;
    logic        chk;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic iv, logic [1:0] sel, logic ordy, logic fl,
                              logic ov, logic ir, logic chk, logic [31:0] data);
    vec_t v;
    v.iv = iv; v.sel = sel; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.ir = ir; v.chk = chk; v.data = data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ch0;
    logic [1:0]  vs;
    in_data  = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    in_data3 = {32'h3300_0002, 32'h3300_0001, 32'h3300_0000};

    // Reset values
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_out_sel",   32'(out_sel),   32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    #2 rst_n = 1'b1;
    tick();

    // Streaming, back-pressure and flush vectors: inputs before an edge, outputs after it
    vecs[0]  = mk(1, 2'd0, 1, 0, 1, 1, 1, 32'hA000_0000);
    vecs[1]  = mk(1, 2'd1, 1, 0, 1, 1, 1, 32'hA000_0001);
    vecs[2]  = mk(1, 2'd2, 1, 0, 1, 1, 1, 32'hA000_0002);
    vecs[3]  = mk(1, 2'd3, 1, 0, 1, 1, 1, 32'hA000_0003);
    vecs[4]  = mk(0, 2'd0, 1, 0, 0, 1, 0, 32'h0);
    vecs[5]  = mk(1, 2'd0, 0, 0, 1, 1, 1, 32'hA000_0000);
    vecs[6]  = mk(1, 2'd1, 0, 0, 1, 0, 1, 32'hA000_0000);
    vecs[7]  = mk(1, 2'd2, 0, 0, 1, 0, 1, 32'hA000_0000);
    vecs[8]  = mk(0, 2'd0, 1, 0, 1, 1, 1, 32'hA000_0001);
    vecs[9]  = mk(0, 2'd0, 1, 0, 0, 1, 0, 32'h0);
    vecs[10] = mk(1, 2'd2, 0, 0, 1, 1, 1, 32'hA000_0002);
    vecs[11] = mk(1, 2'd3, 0, 0, 1, 0, 1, 32'hA000_0002);
    vecs[12] = mk(1, 2'd1, 0, 1, 0, 1, 0, 32'h0);
    vecs[13] = mk(1, 2'd1, 1, 1, 0, 1, 0, 32'h0);
    vecs[14] = mk(0, 2'd0, 1, 0, 0, 1, 0, 32'h0);

    foreach (vecs[i]) begin
      in_valid = vecs[i].iv; in_sel = vecs[i].sel;
      out_ready = vecs[i].ordy; flush = vecs[i].fl;
      tick();
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].ir));
      if (vecs[i].chk) begin
        chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].data);
        vs = vecs[i].data[1:0];
        chk($sformatf("vec%0d_out_sel", i), 32'(out_sel), 32'(vs));
      end
    end
    in_valid = 1'b0; flush = 1'b0;

    // Async reset in state TWO, checked before any clock edge
    in_valid = 1'b1; in_sel = 2'd0; out_ready = 1'b0;
    tick();
    in_sel = 2'd1;
    tick();
    in_valid = 1'b0;
    chk("two_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready",  32'(in_ready),  32'd1);
    chk("async_rst_out_data",  out_data,       32'd0);
    tick();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Range check on the N=3 instance
    in_valid3 = 1'b1; in_sel3 = 2'd2;
    tick();
    chk("n3_sel2_data", out_data3, 32'h3300_0002);
    chk("n3_sel2_err",  32'(out_err3), 32'd0);
    in_sel3 = 2'd3;
    tick();
    in_valid3 = 1'b0;
    chk("n3_sel3_sel", 32'(out_sel3), 32'd3);
`ifdef MUX_SEL_RANGE_CHECK_EN
    chk("n3_sel3_data", out_data3, 32'h0);
    chk("n3_sel3_err",  32'(out_err3), 32'd1);
`else
    chk("n3_sel3_data", out_data3, 32'h3300_0000);
    chk("n3_sel3_err",  32'(out_err3), 32'd0);
`endif

    // Random stall with scoreboard; occupancy model comes from the expected queue
    exp_q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic iv_r, ordy_r;
      logic [1:0] sel_r;
      iv_r   = ($urandom_range(0, 3) != 0);
      ordy_r = ($urandom_range(0, 2) != 0);
      sel_r  = 2'($urandom_range(0, 3));
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_valid = iv_r; out_ready = ordy_r; in_sel = sel_r;
      #1;
      chk("rnd_out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      chk("rnd_in_ready",  32'(in_ready),  32'(exp_q.size() < 2));
      if (out_valid && ordy_r) begin
        if (exp_q.size() == 0) chk("rnd_underflow", 32'd1, 32'd0);
        else                   chk("rnd_out_data", out_data, exp_q.pop_front());
      end
      if (iv_r && in_ready) begin
        ch0 = in_data[sel_r*32 +: 32];
        exp_q.push_back(ch0);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("drain_underflow", 32'd1, 32'd0);
        else                   chk("drain_out_data", out_data, exp_q.pop_front());
      end
      tick();
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
